// File: rtl/arm_control_unit.sv
// arm_control_unit: instruction decode, NZCV flag register, condition check and IDLE/RUN/HALT sequencing.
// Latency: the Control word is combinational from InstrControl (0 cycles). flags, state and the counters update at the next edge.
// Backpressure: none. In IDLE and HALT the unit gates the PC and all write enables, and start resumes execution.
//
// Ports: clk/rst (sync, active-high), start (resume pulse), InstrControl = Instr[31:12],
//        ALUFlags = {N,Z,C,V} of the current cycle, Control = 13-bit datapath control word,
//        pc_en, flags (registered NZCV), state (00 IDLE, 01 RUN, 10 HALT), issued_count.
// Optional: define CTRL_SKIP_CNT_EN to add skipped_count (counted instructions that failed their condition).
module arm_control_unit #(
  parameter int CNT_W          = 16,
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [19:0]      InstrControl,
  input  logic [3:0]       ALUFlags,
  output logic [12:0]      Control,
  output logic             pc_en,
  output logic [3:0]       flags,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] issued_count
`ifdef CTRL_SKIP_CNT_EN
  ,
  output logic [CNT_W-1:0] skipped_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t st;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;

  assign cond  = InstrControl[19:16];
  assign op    = InstrControl[15:14];
  assign funct = InstrControl[13:8];
  assign rd    = InstrControl[3:0];
  assign cmd   = funct[4:1];

  // Rn is only consumed by the register file, not by this control unit.
  logic unused_rn;
  assign unused_rn = ^InstrControl[7:4];

  // Raw decode, before condition and FSM gating.
  logic       pcsrc_d, memtoreg_d, memwrite_d, alusrc_d, regwrite_d;
  logic [3:0] alu_d;
  logic [1:0] immsrc_d, regsrc_d;
  logic       setflags_d;   // instruction updates flags
  logic       upd_all_d;    // 1: load NZCV, 0: load N and Z only
  logic       illegal_d;
  logic       dp_ok, is_cmp;

  always_comb begin
    pcsrc_d    = 1'b0;
    memtoreg_d = 1'b0;
    memwrite_d = 1'b0;
    alusrc_d   = 1'b0;
    regwrite_d = 1'b0;
    alu_d      = 4'b0000;
    immsrc_d   = 2'b00;
    regsrc_d   = 2'b00;
    setflags_d = 1'b0;
    upd_all_d  = 1'b0;
    illegal_d  = 1'b0;
    dp_ok      = 1'b1;
    is_cmp     = 1'b0;
    case (op)
      2'b00: begin
        case (cmd)
          4'b0100: begin alu_d = 4'b0000; upd_all_d = 1'b1; end // ADD
          4'b0010: begin alu_d = 4'b0001; upd_all_d = 1'b1; end // SUB
          4'b0000: alu_d = 4'b0010;                              // AND
          4'b1100: alu_d = 4'b0011;                              // ORR
          4'b0001: alu_d = 4'b0100;                              // EOR
          4'b1101: alu_d = 4'b0101;                              // MOV
          4'b1010: begin alu_d = 4'b0001; upd_all_d = 1'b1; is_cmp = 1'b1; end
          default: dp_ok = 1'b0;
        endcase
        // Unsupported commands fall through as a NOP with every field zero.
        if (dp_ok) begin
          alusrc_d   = funct[5];
          regwrite_d = ~is_cmp;
          setflags_d = funct[0] | is_cmp;
        end else begin
          alu_d     = 4'b0000;
          upd_all_d = 1'b0;
        end
      end
      2'b01: begin
        alusrc_d = 1'b1;
        immsrc_d = 2'b01;
        alu_d    = funct[3] ? 4'b0000 : 4'b0001;
        if (funct[0]) begin
          memtoreg_d = 1'b1;
          regwrite_d = 1'b1;
        end else begin
          memwrite_d = 1'b1;
          regsrc_d   = 2'b10;
        end
      end
      2'b10: begin
        immsrc_d = 2'b10;
        alusrc_d = 1'b1;
        regsrc_d = 2'b01;
        pcsrc_d  = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // ARM condition check against the registered flags.
  logic cond_ex;
  always_comb begin
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // A halting instruction is neither executed nor counted.
  logic halt_now, counted, exec;
  assign halt_now = (st == S_RUN) && ((cond == 4'b1111) || illegal_d);
  assign counted  = (st == S_RUN) && !halt_now;
  assign exec     = counted && cond_ex;

  // A register write to R15 is a jump.
  assign Control = {(pcsrc_d | (regwrite_d && (rd == 4'hF))) & exec,
                    memtoreg_d,
                    memwrite_d & exec,
                    alu_d,
                    alusrc_d,
                    immsrc_d,
                    regwrite_d & exec,
                    regsrc_d};

  assign pc_en = (st == S_RUN);
  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= START_ON_RESET ? S_RUN : S_IDLE;
      flags        <= 4'b0000;
      issued_count <= '0;
    end else begin
      case (st)
        S_IDLE:  if (start) st <= S_RUN;
        S_RUN:   if (halt_now) st <= S_HALT;
        S_HALT:  if (start) st <= S_RUN;
        default: st <= S_IDLE;
      endcase
      if (exec && setflags_d) begin
        if (upd_all_d) flags <= ALUFlags;
        else           flags[3:2] <= ALUFlags[3:2];
      end
      if (counted && (issued_count != CNT_MAX))
        issued_count <= issued_count + 1'b1;
    end
  end

`ifdef CTRL_SKIP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      skipped_count <= '0;
    else if (counted && !cond_ex && (skipped_count != CNT_MAX))
      skipped_count <= skipped_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_arm_control_unit.sv
// tb_arm_control_unit: randomized and directed stimulus against a behavioural reference model.
// Latency: the model predicts combinational outputs before each edge and register state after it.
// Backpressure: not applicable.
module tb_arm_control_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] InstrControl;
  logic [3:0]  ALUFlags;

  logic [12:0] control_a, control_b;
  logic        pc_en_a, pc_en_b;
  logic [3:0]  flags_a, flags_b;
  logic [1:0]  state_a, state_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
`ifdef CTRL_SKIP_CNT_EN
  logic [15:0] skip_a;
  logic [1:0]  skip_b;
`endif

  arm_control_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .InstrControl(InstrControl), .ALUFlags(ALUFlags),
    .Control(control_a), .pc_en(pc_en_a), .flags(flags_a), .state(state_a), .issued_count(cnt_a)
`ifdef CTRL_SKIP_CNT_EN
    , .skipped_count(skip_a)
`endif
  );

  // Narrow-counter instance sharing the same stimulus, to exercise saturation.
  arm_control_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .InstrControl(InstrControl), .ALUFlags(ALUFlags),
    .Control(control_b), .pc_en(pc_en_b), .flags(flags_b), .state(state_b), .issued_count(cnt_b)
`ifdef CTRL_SKIP_CNT_EN
    , .skipped_count(skip_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: 0 idle, 1 run, 2 halt.
  int         m_state;
  logic [3:0] m_flags;
  int         m_cnt;
  int         m_skip;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Condition groups are pairs: odd codes are the negation of the even one below.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Expected ungated control word; mask selects the bits the instruction defines.
  // fk: 0 no flag update, 1 load NZCV, 2 load NZ.
  function automatic void ref_decode(input logic [19:0] ic, output logic [12:0] w,
                                     output logic [12:0] mask, output int fk, output bit bad);
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    bit known, cmp;
    op = ic[15:14]; fn = ic[13:8];
    w = '0; mask = '1; fk = 0; bad = 0;
    if (op == 2'b00) begin
      known = 1; cmp = 0; alu = 0;
      case (fn[4:1])
        4'b0100: begin alu = 0; fk = 1; end
        4'b0010: begin alu = 1; fk = 1; end
        4'b0000: begin alu = 2; fk = 2; end
        4'b1100: begin alu = 3; fk = 2; end
        4'b0001: begin alu = 4; fk = 2; end
        4'b1101: begin alu = 5; fk = 2; end
        4'b1010: begin alu = 1; fk = 1; cmp = 1; end
        default: known = 0;
      endcase
      if (!known) begin
        fk = 0;
        mask = 13'b1_0_1_0000_0_00_1_00;
      end else begin
        w[9:6] = alu;
        w[5]   = fn[5];
        w[2]   = !cmp;
        if (!(fn[0] || cmp)) fk = 0;
      end
    end else if (op == 2'b01) begin
      w[5] = 1; w[4:3] = 2'b01;
      w[9:6] = fn[3] ? 4'd0 : 4'd1;
      if (fn[0]) begin w[11] = 1; w[2] = 1; end
      else begin w[10] = 1; w[1:0] = 2'b10; end
    end else if (op == 2'b10) begin
      w[4:3] = 2'b10; w[5] = 1; w[1:0] = 2'b01; w[12] = 1;
    end else begin
      bad = 1;
      mask = 13'b1_0_1_0000_0_00_1_00;
    end
  endfunction

  // One clock cycle: drive, predict and compare before the edge, then advance the model.
  task automatic step(input bit r, input bit s, input logic [19:0] ic, input logic [3:0] af);
    logic [12:0] w, mask;
    int fk;
    bit bad, halt_now, cx, ex;
    @(negedge clk);
    rst = r; start = s; InstrControl = ic; ALUFlags = af;
    #1;
    ref_decode(ic, w, mask, fk, bad);
    halt_now = (m_state == 1) && ((ic[19:16] == 4'hF) || bad);
    cx = cond_ok(ic[19:16], m_flags);
    ex = (m_state == 1) && !halt_now && cx;
    if (w[2] && (ic[3:0] == 4'hF)) w[12] = 1'b1;
    if (!ex) begin w[12] = 1'b0; w[10] = 1'b0; w[2] = 1'b0; end
    check("state", state_a, m_state);
    check("pc_en", pc_en_a, (m_state == 1));
    check("control", control_a & mask, w & mask);
    check("flags", flags_a, m_flags);
    check("issued", cnt_a, sat(m_cnt, 65535));
    check("issued_w2", cnt_b, sat(m_cnt, 3));
`ifdef CTRL_SKIP_CNT_EN
    check("skipped", skip_a, sat(m_skip, 65535));
    check("skipped_w2", skip_b, sat(m_skip, 3));
`endif
    @(posedge clk);
    if (r) begin
      m_state = 0; m_flags = 0; m_cnt = 0; m_skip = 0;
    end else begin
      if (ex && fk == 1) m_flags = af;
      if (ex && fk == 2) m_flags[3:2] = af[3:2];
      if (m_state == 1 && !halt_now) begin
        m_cnt++;
        if (!cx) m_skip++;
      end
      if (m_state == 1 && halt_now) m_state = 2;
      else if (m_state != 1 && s) m_state = 1;
    end
  endtask

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] fn, input logic [3:0] rn, input logic [3:0] rd);
    return {c, op, fn, rn, rd};
  endfunction

  logic [19:0] add_r1, ric;
  logic [3:0]  rc, rcmd;
  logic [1:0]  rop;
  logic [5:0]  rfn;
  logic [12:0] cw;
  int          pick;

  initial begin
    add_r1 = 20'hE0811;
    rst = 1'b1; start = 1'b0; InstrControl = add_r1; ALUFlags = 4'b0000;
    m_state = 0; m_flags = 0; m_cnt = 0; m_skip = 0;
    repeat (2) @(posedge clk);

    // Idle with start low: nothing executes.
    for (int i = 0; i < 5; i++) step(0, 0, add_r1, 4'b0000);
    #1;
    check("idle_state", state_a, 2'b00);
    check("idle_regwrite", control_a[2], 1'b0);
    check("idle_count", cnt_a, 0);

    step(0, 1, add_r1, 4'b0000);

    // SUBS R0,R0,#1 with ALUFlags Z set.
    step(0, 0, mk(4'hE, 2'b00, 6'b100101, 4'h0, 4'h0), 4'b0100);
    #1;
    cw = control_a;
    check("subs_ctrl", cw, {1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'b00, 1'b1, 2'b00});
    check("subs_flags", flags_a, 4'b0100);

    // BNE with Z=1 is not taken, BEQ is.
    step(0, 0, mk(4'h1, 2'b10, 6'b000000, 4'h0, 4'h0), 4'b0000);
    #1;
    check("bne_pcsrc", control_a[12], 1'b0);
    check("bne_count", cnt_a, 2);
    step(0, 0, mk(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0), 4'b0000);
    #1;
    cw = control_a;
    check("beq_pcsrc", cw[12], 1'b1);
    check("beq_immsrc", cw[4:3], 2'b10);
    check("beq_regsrc", cw[1:0], 2'b01);

    // STR with U=1, LDR with U=0.
    step(0, 0, mk(4'hE, 2'b01, 6'b011000, 4'h2, 4'h3), 4'b0000);
    #1;
    cw = control_a;
    check("str_fields", {cw[10], cw[1:0], cw[2], cw[9:6]}, {1'b1, 2'b10, 1'b0, 4'b0000});
    step(0, 0, mk(4'hE, 2'b01, 6'b010001, 4'h2, 4'h3), 4'b0000);
    #1;
    cw = control_a;
    check("ldr_fields", {cw[11], cw[9:6]}, {1'b1, 4'b0001});

    // ADDS loads 1011, ANDS then updates only N and Z.
    step(0, 0, mk(4'hE, 2'b00, 6'b001001, 4'h1, 4'h1), 4'b1011);
    #1 check("adds_flags", flags_a, 4'b1011);
    step(0, 0, mk(4'hE, 2'b00, 6'b000001, 4'h1, 4'h1), 4'b0100);
    #1 check("ands_flags", flags_a, 4'b0111);

    // Halt encoding: not counted, then resume with start.
    step(0, 0, mk(4'hF, 2'b00, 6'b001000, 4'h1, 4'h1), 4'b0000);
    #1;
    check("halt_state", state_a, 2'b10);
    check("halt_count", cnt_a, 7);
    step(0, 0, add_r1, 4'b1111);
    step(0, 1, add_r1, 4'b1111);
    step(0, 0, add_r1, 4'b0000);
    #1 check("resume_count", cnt_a, 8);

    // Reset while running.
    step(1, 0, add_r1, 4'b0000);
    #1;
    check("rst_state", state_a, 2'b00);
    check("rst_flags", flags_a, 4'b0000);
    check("rst_count", cnt_a, 0);

    // Five RUN cycles saturate the 2-bit counter.
    step(0, 1, add_r1, 4'b0000);
    for (int i = 0; i < 5; i++) step(0, 0, add_r1, 4'b0000);
    #1;
    check("sat_w2", cnt_b, 2'd3);
    check("sat_w16", cnt_a, 5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(0, 39);
      rc  = (pick == 0) ? 4'hF : ((pick < 20) ? 4'(($urandom_range(0, 14))) : 4'hE);
      pick = $urandom_range(0, 39);
      rop = (pick == 0) ? 2'b11 : ((pick < 20) ? 2'b00 : ((pick < 30) ? 2'b01 : 2'b10));
      case ($urandom_range(0, 7))
        0: rcmd = 4'b0100;
        1: rcmd = 4'b0010;
        2: rcmd = 4'b0000;
        3: rcmd = 4'b1100;
        4: rcmd = 4'b0001;
        5: rcmd = 4'b1101;
        6: rcmd = 4'b1010;
        default: rcmd = 4'($urandom_range(0, 15));
      endcase
      rfn = {1'($urandom_range(0, 1)), rcmd, 1'($urandom_range(0, 1))};
      if (rop != 2'b00) rfn = 6'($urandom_range(0, 63));
      ric = mk(rc, rop, rfn, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15)));
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0), ric, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
